// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with an output FIFO.
// Scan-code bytes are popped from an upstream receiver FIFO, one every two
// cycles at most. Modifier state (extended, break, shifts, caps) is tracked,
// and mapped make codes are pushed into a 2^DEPTH_LOG2 entry FIFO that a CPU
// drains with io_rdn.
// Optional feature: define KBD_EXT_KEYS_EN to map the extended (0xE0-prefixed)
// arrow keys to ASCII 0x11..0x14. When it is undefined, extended codes only
// suppress output.

module kbd_ascii_decoder #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       sys_clk,
    input  logic       clrn,
    input  logic [7:0] key_data,
    input  logic       key_ready,
    output logic       key_rdn,
    input  logic       io_rdn,
    output logic [7:0] ascii,
    output logic       ascii_ready,
    output logic       ascii_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        DECODE = 1'b1
    } state_t;

    // Returns {valid, ascii} for a plain (non-extended) make code.
    function automatic logic [8:0] map_make(input logic [7:0] code,
                                            input logic       shifted,
                                            input logic       caps_on);
        logic [7:0] lower;
        logic [7:0] plain;
        logic [7:0] upper_sym;
        logic [8:0] result;
        lower     = 8'h00;
        plain     = 8'h00;
        upper_sym = 8'h00;
        result    = 9'h000;
        case (code)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            8'h16: begin plain = "1"; upper_sym = "!"; end
            8'h1E: begin plain = "2"; upper_sym = "@"; end
            8'h26: begin plain = "3"; upper_sym = "#"; end
            8'h25: begin plain = "4"; upper_sym = "$"; end
            8'h2E: begin plain = "5"; upper_sym = "%"; end
            8'h36: begin plain = "6"; upper_sym = "^"; end
            8'h3D: begin plain = "7"; upper_sym = "&"; end
            8'h3E: begin plain = "8"; upper_sym = "*"; end
            8'h46: begin plain = "9"; upper_sym = "("; end
            8'h45: begin plain = "0"; upper_sym = ")"; end
            8'h29: result = {1'b1, 8'h20};
            8'h5A: result = {1'b1, 8'h0D};
            8'h66: result = {1'b1, 8'h08};
            default: ;
        endcase
        // Letters honour caps lock; digits only honour shift.
        if (lower != 8'h00)
            result = {1'b1, (shifted ^ caps_on) ? (lower - 8'h20) : lower};
        else if (plain != 8'h00)
            result = {1'b1, shifted ? upper_sym : plain};
        return result;
    endfunction

`ifdef KBD_EXT_KEYS_EN
    // Returns {valid, ascii} for an extended (0xE0-prefixed) make code.
    function automatic logic [8:0] map_ext(input logic [7:0] code);
        logic [8:0] result;
        result = 9'h000;
        case (code)
            8'h75: result = {1'b1, 8'h11};
            8'h72: result = {1'b1, 8'h12};
            8'h6B: result = {1'b1, 8'h13};
            8'h74: result = {1'b1, 8'h14};
            default: ;
        endcase
        return result;
    endfunction
`endif

    state_t                state_q, state_d;
    logic [7:0]            byte_q, byte_d;
    logic                  ext_q, ext_d;
    logic                  brk_q, brk_d;
    logic                  shift_l_q, shift_l_d;
    logic                  shift_r_q, shift_r_d;
    logic                  caps_q, caps_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            fifo_q [DEPTH];

    logic                  push;
    logic [7:0]            push_data;
    logic                  do_push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    // Upstream pop strobe: asserted while idle with a byte waiting, and forced
    // inactive during reset.
    assign key_rdn = ~(clrn & (state_q == IDLE) & key_ready);

    // Byte fetch / decode sequencing and modifier tracking.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        byte_d    = byte_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        caps_d    = caps_q;
        push      = 1'b0;
        push_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (key_ready) begin
                    byte_d  = key_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (byte_q == 8'h12) begin
                        shift_l_d = ~brk_q;
                    end else if (byte_q == 8'h59) begin
                        shift_r_d = ~brk_q;
                    end else if (byte_q == 8'h58) begin
                        if (!brk_q)
                            caps_d = ~caps_q;
                    end else if (!brk_q) begin
                        if (ext_q) begin
`ifdef KBD_EXT_KEYS_EN
                            {push, push_data} = map_ext(byte_q);
`endif
                        end else begin
                            {push, push_data} = map_make(byte_q,
                                                         shift_l_q | shift_r_q,
                                                         caps_q);
                        end
                    end
                end
            end
        endcase
    end

    // Output FIFO pointer/count bookkeeping; a push into a full FIFO only
    // succeeds when a pop frees a slot on the same edge.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == FULL_COUNT);
        pop        = ~io_rdn & ~empty;
        do_push    = push & (~full | pop);
        overflow_d = overflow_q | (push & full & ~pop);
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and modifier state registers.
    always_ff @(posedge sys_clk or negedge clrn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!clrn) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            caps_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            caps_q     <= caps_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge sys_clk or negedge clrn) begin
        // NOTE: the storage array is reset on purpose so the head reads 0x00
        // straight out of reset; this keeps it in flops rather than RAM.
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= 8'h00;
        end else if (do_push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign ascii          = fifo_q[rd_ptr_q];
    assign ascii_ready    = ~empty;
    assign ascii_overflow = overflow_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Directed bench for kbd_ascii_decoder. Expected ASCII codes are queued when
// the scan codes are fed and compared when the CPU side pops the FIFO.
// Honours KBD_EXT_KEYS_EN for the extended-key expectations.

module tb_kbd_ascii_decoder;

    logic       sys_clk = 1'b0;
    logic       clrn;
    logic [7:0] key_data;
    logic       key_ready;
    logic       key_rdn;
    logic       io_rdn;
    logic [7:0] ascii;
    logic       ascii_ready;
    logic       ascii_overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    kbd_ascii_decoder #(.DEPTH_LOG2(3)) dut (
        .sys_clk        (sys_clk),
        .clrn           (clrn),
        .key_data       (key_data),
        .key_ready      (key_ready),
        .key_rdn        (key_rdn),
        .io_rdn         (io_rdn),
        .ascii          (ascii),
        .ascii_ready    (ascii_ready),
        .ascii_overflow (ascii_overflow)
    );

    always #10 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the FIFO head with the oldest expected code, then pop it.
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_nothing_expected"}, 8'(ascii_ready), 8'h00);
            return;
        end
        exp = sb.pop_front();
        check({tag, "_ready"}, 8'(ascii_ready), 8'h01);
        check(tag, ascii, exp);
        io_rdn = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        io_rdn = 1'b1;
    endtask

    // Offer one upstream byte and let it be fetched and decoded. Starts and
    // ends on a falling edge. With do_pop set, the CPU pops on the decode edge.
    task automatic feed(input logic [7:0] b, input bit do_pop = 1'b0);
        int budget;
        logic [7:0] exp;
        budget    = 0;
        key_data  = b;
        key_ready = 1'b1;
        #1;
        while (key_rdn !== 1'b0 && budget < 10) begin
            @(negedge sys_clk);
            #1;
            budget++;
        end
        check("key_rdn_ack", 8'(key_rdn), 8'h00);
        @(posedge sys_clk);
        @(negedge sys_clk);
        key_ready = 1'b0;
        check("key_rdn_in_decode", 8'(key_rdn), 8'h01);
        if (do_pop) begin
            exp = sb.pop_front();
            check("pop_on_decode", ascii, exp);
            io_rdn = 1'b0;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        io_rdn = 1'b1;
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0)
            pop_check(tag);
        check({tag, "_empty"}, 8'(ascii_ready), 8'h00);
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        clrn = 1'b0;
        @(negedge sys_clk);
        clrn = 1'b1;
        sb.delete();
    endtask

    initial begin
        clrn      = 1'b0;
        io_rdn    = 1'b1;
        key_data  = 8'h00;
        key_ready = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("rst_key_rdn", 8'(key_rdn), 8'h01);
        check("rst_ascii", ascii, 8'h00);
        check("rst_ready", 8'(ascii_ready), 8'h00);
        check("rst_overflow", 8'(ascii_overflow), 8'h00);
        key_ready = 1'b0;
        clrn      = 1'b1;
        @(negedge sys_clk);

        // Make, break, make of 'a': exactly one entry.
        feed(8'h1C); sb.push_back(8'h61);
        feed(8'hF0);
        feed(8'h1C);
        check("a_break_ready", 8'(ascii_ready), 8'h01);
        check("a_break_head", ascii, 8'h61);
        drain("a_break");

        // Shifted letter, then shift released.
        feed(8'h12);
        feed(8'h1C); sb.push_back(8'h41);
        feed(8'hF0);
        feed(8'h12);
        feed(8'h1C); sb.push_back(8'h61);
        drain("shift");

        // Caps lock on: digits unaffected, letters upper case.
        feed(8'h58);
        feed(8'hF0);
        feed(8'h58);
        feed(8'h16); sb.push_back(8'h31);
        feed(8'h1C); sb.push_back(8'h41);
        drain("caps");
        feed(8'h58);
        feed(8'hF0);
        feed(8'h58);

        // Shifted digits, space/enter/backspace, unmapped and break codes.
        feed(8'h59);
        feed(8'h16); sb.push_back(8'h21);
        feed(8'h45); sb.push_back(8'h29);
        feed(8'h1A); sb.push_back(8'h5A);
        feed(8'hF0);
        feed(8'h59);
        feed(8'h29); sb.push_back(8'h20);
        feed(8'h5A); sb.push_back(8'h0D);
        feed(8'h66); sb.push_back(8'h08);
        feed(8'h76);
        feed(8'hF0);
        feed(8'h32);
        drain("misc");

        // CPU read while empty is ignored.
        io_rdn = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        io_rdn = 1'b1;
        check("empty_pop_ready", 8'(ascii_ready), 8'h00);
        feed(8'h32); sb.push_back(8'h62);
        drain("after_empty_pop");

        // Nine pushes into an 8-deep FIFO: last one dropped.
        for (int i = 0; i < 9; i++) begin
            feed(8'h29);
            if (i < 8) sb.push_back(8'h20);
        end
        check("ovf_flag", 8'(ascii_overflow), 8'h01);
        drain("ovf");
        check("ovf_sticky", 8'(ascii_overflow), 8'h01);

        // Full FIFO with simultaneous push and pop; pointers wrap.
        pulse_reset();
        check("post_rst_overflow", 8'(ascii_overflow), 8'h00);
        feed(8'h1C); sb.push_back(8'h61);
        feed(8'h32); sb.push_back(8'h62);
        feed(8'h21); sb.push_back(8'h63);
        feed(8'h23); sb.push_back(8'h64);
        feed(8'h24); sb.push_back(8'h65);
        feed(8'h2B); sb.push_back(8'h66);
        feed(8'h34); sb.push_back(8'h67);
        feed(8'h33); sb.push_back(8'h68);
        sb.push_back(8'h69);
        feed(8'h43, 1'b1);
        check("full_pushpop_overflow", 8'(ascii_overflow), 8'h00);
        drain("wrap");

        // Extended prefix.
        feed(8'hE0);
        feed(8'h75);
`ifdef KBD_EXT_KEYS_EN
        sb.push_back(8'h11);
`endif
        check("ext_ready", 8'(ascii_ready), (sb.size() != 0) ? 8'h01 : 8'h00);
        drain("ext");
        feed(8'hE0);
        feed(8'h1C);
        feed(8'h1C); sb.push_back(8'h61);
        drain("ext_clear");

        // Reset asserted mid-DECODE with a non-empty FIFO.
        feed(8'h1C);
        key_data  = 8'h32;
        key_ready = 1'b1;
        @(posedge sys_clk);
        #2;
        clrn = 1'b0;
        #1;
        check("mid_rst_ready", 8'(ascii_ready), 8'h00);
        check("mid_rst_ascii", ascii, 8'h00);
        check("mid_rst_overflow", 8'(ascii_overflow), 8'h00);
        check("mid_rst_key_rdn", 8'(key_rdn), 8'h01);
        sb.delete();
        key_ready = 1'b0;
        @(negedge sys_clk);
        clrn = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("mid_rst_byte_lost", 8'(ascii_ready), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
